// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one request in flight to
// instruction memory, buffers returned words in a 2-entry FIFO and presents {pc, instr}
// to the IF/ID register. A redirect flushes the FIFO and squashes any in-flight return.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  // StWait keeps the returning word, StDrop throws it away (request predates a redirect).
  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];
  logic [1:0]  count_q, count_d;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;

  logic        pop, push, space, accept;
  logic [2:0]  count_nxt;

  assign valid_o = (count_q != 2'd0);
  assign instr_o = valid_o ? fifo_instr_q[rptr_q] : 32'h0;
  assign pc_o    = valid_o ? fifo_pc_q[rptr_q] : fetch_pc_q;

  assign pop  = valid_o & ~stall & ~redirect;
  assign push = imem_rvalid & (state_q == StWait) & ~redirect;

  // Occupancy after this cycle; a new request needs a free slot for its eventual return.
  assign count_nxt = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};
  assign space     = (count_nxt < 3'd2);

  // Gated with reset so no request escapes while reset is held.
  assign imem_req  = rst & ~redirect & space &
                     ((state_q == StIdle) | ((state_q == StWait) & imem_rvalid));
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req & imem_ready;

  // Next-state for FSM, PCs, FIFO occupancy and pointers; redirect wins over everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (redirect) begin
      count_d    = 2'd0;
      wptr_d     = 1'b0;
      rptr_d     = 1'b0;
      fetch_pc_d = redirect_pc;
      if (state_q == StWait) begin
        state_d = imem_rvalid ? StIdle : StDrop;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) state_d = StWait;
        end
        StWait: begin
          if (accept)           state_d = StWait;
          else if (imem_rvalid) state_d = StIdle;
        end
        StDrop: begin
          if (imem_rvalid) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
      if (accept) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      count_d = count_nxt[1:0];
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      count_q    <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage; only written on a kept return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_pc_q[0]    <= 32'h0;
      fifo_pc_q[1]    <= 32'h0;
      fifo_instr_q[0] <= 32'h0;
      fifo_instr_q[1] <= 32'h0;
    end else if (push) begin
      fifo_pc_q[wptr_q]    <= req_pc_q;
      fifo_instr_q[wptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a behavioural memory model returns ~addr as data,
// kept returns are pushed to a scoreboard queue and popped as the DUT presents them.
module tb_if_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  if_fetch #(.RESET_PC(ResetPc)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .valid_o    (valid_o),
    .instr_o    (instr_o),
    .pc_o       (pc_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory / reference model state
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_dly = 0;
  int          pend_epoch = 0;
  int          epoch = 0;
  logic [31:0] exp_fetch = ResetPc;
  logic [31:0] exp_next_pc = ResetPc;
  logic [63:0] sb_q[$];
  bit          rnd = 1'b0;
  int          fixed_dly = 0;
  bit          saw_wrap = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs on negedge, check at +1, update model at posedge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input bit stale,
                      output logic s_req, output logic s_valid, output logic [31:0] s_pc);
    logic        acc;
    logic [31:0] acc_addr;
    logic [63:0] e;
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = (pend && pend_dly == 0) || stale;
    imem_rdata  = stale ? 32'hDEAD_BEEF : ~pend_addr;
    imem_ready  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    #1;
    s_req   = imem_req;
    s_valid = valid_o;
    s_pc    = pc_o;
    check("valid_o", 32'(valid_o), 32'(sb_q.size() != 0));
    if (valid_o) begin
      if (sb_q.size() != 0) begin
        e = sb_q[0];
        check("pc_o", pc_o, e[63:32]);
        check("instr_o", instr_o, e[31:0]);
        if (!st && !rd) begin
          void'(sb_q.pop_front());
          check("pc_seq", pc_o, exp_next_pc);
          exp_next_pc = exp_next_pc + 32'd4;
          if (pc_o == 32'h0) saw_wrap = 1'b1;
        end
      end
    end else begin
      check("pc_o_empty", pc_o, exp_fetch);
      check("instr_o_empty", instr_o, 32'h0);
    end
    if (rd) check("req_on_redirect", 32'(imem_req), 32'h0);
    if (imem_req) begin
      check("imem_addr", imem_addr, exp_fetch);
      check("one_outstanding", 32'(pend && !imem_rvalid), 32'h0);
    end
    acc      = imem_req && imem_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    if (imem_rvalid && !stale) begin
      if (pend_epoch == epoch && !rd) sb_q.push_back({pend_addr, ~pend_addr});
      pend = 1'b0;
    end else if (pend && pend_dly > 0) begin
      pend_dly--;
    end
    if (rd) begin
      epoch++;
      sb_q.delete();
      exp_fetch   = rpc;
      exp_next_pc = rpc;
    end
    if (acc) begin
      pend       = 1'b1;
      pend_addr  = acc_addr;
      pend_epoch = epoch;
      pend_dly   = rnd ? int'($urandom_range(0, 3)) : fixed_dly;
      exp_fetch  = exp_fetch + 32'd4;
    end
  endtask

  logic        r_req, r_valid;
  logic [31:0] r_pc, held_pc, rpc;
  bit          st, rd;

  initial begin
    // Reset held
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_pc", pc_o, ResetPc);
    rst = 1'b1;

    // Zero-wait streaming
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("first_req", 32'(r_req), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("first_valid_lat", 32'(r_valid), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
      check("zw_valid", 32'(r_valid), 32'h1);
      check("zw_pc", r_pc, ResetPc + 32'(4 * i));
    end

    // Stall fills the FIFO, then drains in order
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
      if (i == 0) held_pc = r_pc;
      check("stall_hold_pc", r_pc, held_pc);
    end
    check("stall_full_req", 32'(r_req), 32'h0);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);

    // Redirect while WAIT without rvalid -> DROP
    fixed_dly = 2;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
      if (pend && pend_dly == 2) break;
    end
    check("drop_setup", 32'(pend && pend_dly == 2), 32'h1);
    step(1'b0, 1'b1, 32'h200, 1'b0, r_req, r_valid, r_pc);
    fixed_dly = 0;
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("drop_req0", 32'(r_req), 32'h0);
    check("drop_valid0", 32'(r_valid), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("drop_ret_req0", 32'(r_req), 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("drop_refetch", 32'(r_req), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("redir_first_valid", 32'(r_valid), 32'h1);
    check("redir_first_pc", r_pc, 32'h200);

    // Redirect coincident with rvalid -> straight to IDLE
    for (int i = 0; i < 20; i++) begin
      if (pend && pend_dly == 0) break;
      step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    end
    check("rv_redir_setup", 32'(pend && pend_dly == 0), 32'h1);
    step(1'b0, 1'b1, 32'h300, 1'b0, r_req, r_valid, r_pc);
    step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("rv_redir_req", 32'(r_req), 32'h1);
    check("rv_redir_valid", 32'(r_valid), 32'h0);
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);

    // Random ready/latency/stall/redirect
    rnd = 1'b1;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = $urandom();
      rpc[1:0] = 2'b00;
      step(st, rd, rpc, 1'b0, r_req, r_valid, r_pc);
    end

    // Fetch PC wraps past 32'hFFFF_FFFC
    rnd = 1'b0;
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    saw_wrap = 1'b0;
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, r_req, r_valid, r_pc);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
    check("wrap_seen", 32'(saw_wrap), 32'h1);

    // Asynchronous reset mid-WAIT, then a stale rvalid after release
    fixed_dly = 3;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);
      if (pend && pend_dly == 3) break;
    end
    check("arst_setup", 32'(pend && pend_dly == 3), 32'h1);
    @(negedge clk);
    stall = 1'b0;
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_req", 32'(imem_req), 32'h0);
    check("arst_valid", 32'(valid_o), 32'h0);
    check("arst_instr", instr_o, 32'h0);
    check("arst_pc", pc_o, ResetPc);
    pend = 1'b0;
    epoch++;
    sb_q.delete();
    exp_fetch = ResetPc;
    exp_next_pc = ResetPc;
    fixed_dly = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1, r_req, r_valid, r_pc);
    check("post_rst_req", 32'(r_req), 32'h1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, r_req, r_valid, r_pc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
